regfile_wb_bypass: RTL and testbench
====================================

Name: regfile_wb_bypass

Overview:
- Parametrised register file for the multi-cycle datapath: two registered read ports and one clocked write port.
- Write-back destination select (rd/rt) and source select (ALU/MDR) are built in.
- Optional read-after-write bypass and an optional hardwired zero register.
- After reset, a sequencer clears the array one entry per cycle while holding the block busy.

Parameters:
- DATA_W, 32, data width of every register.
- ADDR_W, 5, width of all register address fields.
- DEPTH, 32, number of implemented registers (1..2^ADDR_W).
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1, a read of the address being written in the same cycle returns the new data.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address; also write address when regdst=0
- rd_addr  input  ADDR_W  write address when regdst=1
- regdst  input  1  1: write to rd_addr, 0: write to rt_addr
- regwrite  input  1  write request this cycle
- memtoreg  input  1  1: write data = mdr_result, 0: write data = alu_result
- alu_result  input  DATA_W  ALU write-back data
- mdr_result  input  DATA_W  memory data register write-back data
- rs_data  output  DATA_W  registered read data, port A
- rt_data  output  DATA_W  registered read data, port B
- clr_busy  output  1  high while the clear sequence runs
- wr_drop  output  1  one-cycle pulse: a requested write was discarded

Behaviour:
- All state updates on the rising clk edge. No combinational path from inputs to outputs.
- Reset (rst=1 at an edge):
  - rs_data=0, rt_data=0, wr_drop=0, clr_busy=1, clear pointer=0.
  - No array write occurs.
  - rst asserted mid-clear restarts the pointer at 0.
- Clear sequence:
  - Each edge with rst=0 and clr_busy=1 writes 0 to entry[ptr], then ptr increments.
  - On the edge that clears entry DEPTH-1, clr_busy goes to 0.
  - clr_busy is therefore high for exactly DEPTH cycles after rst deasserts.
- Write decode:
  - waddr = regdst ? rd_addr : rt_addr.
  - wdata = memtoreg ? mdr_result : alu_result.
  - Commit condition: regwrite=1, clr_busy=0, waddr<DEPTH, and not (ZERO_REG=1 and waddr=0).
  - On commit, entry[waddr] <= wdata at the edge.
- wr_drop <= regwrite and not commit.
  - Covers writes during clear, out-of-range writes, and writes to reg0 with ZERO_REG=1.
  - Registered: it pulses the cycle after the request.
  - wr_drop is 0 while rst=1.
- Read, 1-cycle latency; each port evaluated independently at each edge:
  - rst=1 or clr_busy=1 -> 0.
  - Else addr>=DEPTH -> 0.
  - Else ZERO_REG=1 and addr=0 -> 0.
  - Else BYPASS=1 and commit and waddr=addr -> wdata.
  - Else entry[addr], the pre-edge value.
- With BYPASS=0, a same-cycle read of the written address returns the old value; the new value is visible on the following read.
- Both ports reading the same address return identical data.
- Write and both reads may all target one address in the same cycle.
- The array has no other initialisation; contents are defined only after the clear sequence completes.

Test Plan:
- Clear: DEPTH=32, assert rst 2 cycles, release -> clr_busy high exactly 32 cycles. regwrite=1 at waddr 5 during the clear -> wr_drop pulses and entry 5 reads 0 after the clear.
- Basic write/read: regdst=1, rd=7, memtoreg=0, alu_result=0x0000_00A5, regwrite=1. Next cycle rs_addr=7 -> rs_data=0x0000_00A5 one edge later. Same sequence with memtoreg=1, mdr_result=0xDEAD_BEEF, regdst=0, rt=3 -> reg3=0xDEAD_BEEF.
- Bypass: same cycle, write 0x1234_5678 to reg 9 with rs_addr=rt_addr=9. BYPASS=1 -> both ports return 0x1234_5678. BYPASS=0 -> both return the prior value 0, then 0x1234_5678 on the next read.
- Zero register: ZERO_REG=1, write 0xFFFF_FFFF to reg 0 -> wr_drop pulses and reads of reg 0 return 0. ZERO_REG=0 -> reg 0 reads 0xFFFF_FFFF.
- Range: DEPTH=10, ADDR_W=5, write to 12 -> wr_drop=1. Read of 12 -> 0; entries 0..9 unchanged.
- Reset mid-operation: assert rst at clear pointer 20 -> the pointer restarts and clr_busy stays high 32 more cycles. Assert rst after reg4=0x55 has been written -> after the clear, reg4 reads 0.

Source files
------------

// File: rtl/regfile_wb_bypass.sv
// Register file with built-in write-back mux, optional read-after-write bypass and
// hardwired zero register; clears itself one entry per cycle after reset.
module regfile_wb_bypass #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              regdst,
   input  logic              regwrite,
   input  logic              memtoreg,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mdr_result,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              clr_busy,
   output logic              wr_drop
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] clr_ptr_q;
   logic              clr_busy_q;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic              wr_drop_q, wr_drop_d;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              commit;

   always_comb begin
      waddr     = regdst ? rd_addr : rt_addr;
      wdata     = memtoreg ? mdr_result : alu_result;
      commit    = regwrite && !clr_busy_q && (32'(waddr) < DEPTH)
                  && !(ZERO_REG != 0 && waddr == '0);
      wr_drop_d = regwrite && !commit;
   end

   // Unmatched (out-of-range) addresses fall through to zero; bypass only fires
   // on a commit, so it can never resurrect an out-of-range or zero-reg address.
   always_comb begin
      rs_data_d = '0;
      rt_data_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (rs_addr == ADDR_W'(i)) rs_data_d = mem_q[i];
         if (rt_addr == ADDR_W'(i)) rt_data_d = mem_q[i];
      end
      if (BYPASS != 0 && commit) begin
         if (rs_addr == waddr) rs_data_d = wdata;
         if (rt_addr == waddr) rt_data_d = wdata;
      end
      if (ZERO_REG != 0) begin
         if (rs_addr == '0) rs_data_d = '0;
         if (rt_addr == '0) rt_data_d = '0;
      end
      if (clr_busy_q) begin
         rs_data_d = '0;
         rt_data_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clr_busy_q) begin
               if (clr_ptr_q == ADDR_W'(i)) mem_q[i] <= '0;
            end else if (commit && waddr == ADDR_W'(i)) begin
               mem_q[i] <= wdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_busy_q <= 1'b1;
         clr_ptr_q  <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         wr_drop_q  <= 1'b0;
      end else begin
         if (clr_busy_q) begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) clr_busy_q <= 1'b0;
         end
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   assign rs_data  = rs_data_q;
   assign rt_data  = rt_data_q;
   assign clr_busy = clr_busy_q;
   assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_wb_bypass.sv
// Bench for regfile_wb_bypass: two configurations driven in lock-step, each checked
// against an array-based model of the register file rules.
module tb_regfile_wb_bypass;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
   logic        regdst = 1'b0, regwrite = 1'b0, memtoreg = 1'b0;
   logic [31:0] alu_result = '0, mdr_result = '0;

   logic [31:0] rs_data [2];
   logic [31:0] rt_data [2];
   logic        clr_busy [2];
   logic        wr_drop [2];

   regfile_wb_bypass #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
      .alu_result(alu_result), .mdr_result(mdr_result),
      .rs_data(rs_data[0]), .rt_data(rt_data[0]), .clr_busy(clr_busy[0]), .wr_drop(wr_drop[0]));

   regfile_wb_bypass #(.DATA_W(32), .ADDR_W(5), .DEPTH(10), .ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
      .alu_result(alu_result), .mdr_result(mdr_result),
      .rs_data(rs_data[1]), .rt_data(rt_data[1]), .clr_busy(clr_busy[1]), .wr_drop(wr_drop[1]));

   int unsigned DEP [2];
   bit          ZR [2];
   bit          BP [2];
   logic [31:0] mm [2][32];
   int unsigned mcnt [2];
   logic [31:0] e_rs [2];
   logic [31:0] e_rt [2];
   logic        e_busy [2];
   logic        e_drop [2];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mread(input int k, input logic [4:0] a, input bit busy,
                                         input bit commit, input logic [4:0] wa,
                                         input logic [31:0] wd);
      int unsigned ai;
      ai = a;
      if (busy) return '0;
      if (ai >= DEP[k]) return '0;
      if (ZR[k] && ai == 0) return '0;
      if (BP[k] && commit && wa == a) return wd;
      return mm[k][ai];
   endfunction

   task automatic step();
      bit          busy, commit;
      logic [4:0]  wa;
      logic [31:0] wd;
      int unsigned wai;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            e_rs[k] = '0; e_rt[k] = '0; e_drop[k] = 1'b0;
            mcnt[k] = DEP[k];
            for (int i = 0; i < 32; i++) mm[k][i] = '0;
         end else begin
            busy   = (mcnt[k] != 0);
            wa     = regdst ? rd_addr : rt_addr;
            wd     = memtoreg ? mdr_result : alu_result;
            wai    = wa;
            commit = regwrite && !busy && (wai < DEP[k]) && !(ZR[k] && wai == 0);
            e_rs[k]   = mread(k, rs_addr, busy, commit, wa, wd);
            e_rt[k]   = mread(k, rt_addr, busy, commit, wa, wd);
            e_drop[k] = regwrite && !commit;
            if (busy) mcnt[k]--;
            if (commit) mm[k][wai] = wd;
         end
         e_busy[k] = (mcnt[k] != 0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rs_data[%0d]", k), rs_data[k], e_rs[k]);
         check($sformatf("rt_data[%0d]", k), rt_data[k], e_rt[k]);
         check($sformatf("clr_busy[%0d]", k), {31'b0, clr_busy[k]}, {31'b0, e_busy[k]});
         check($sformatf("wr_drop[%0d]", k), {31'b0, wr_drop[k]}, {31'b0, e_drop[k]});
      end
   endtask

   task automatic write(input logic [4:0] a, input bit use_mdr, input logic [31:0] v);
      regwrite = 1'b1; regdst = 1'b1; rd_addr = a; memtoreg = use_mdr;
      if (use_mdr) mdr_result = v; else alu_result = v;
   endtask

   // Counts cycles with clr_busy high, starting from the first cycle after rst drops.
   task automatic run_clear(input bit write_first, output int unsigned ca, output int unsigned cb);
      ca = 0; cb = 0;
      for (int i = 0; i < 40; i++) begin
         if (clr_busy[0]) ca++;
         if (clr_busy[1]) cb++;
         if (write_first && i == 0) begin
            regwrite = 1'b1; regdst = 1'b1; rd_addr = 5'd5; alu_result = 32'h0BAD_0005;
         end else begin
            regwrite = 1'b0;
         end
         step();
      end
   endtask

   initial begin
      int unsigned ca, cb;
      DEP[0] = 32; ZR[0] = 1'b1; BP[0] = 1'b1;
      DEP[1] = 10; ZR[1] = 1'b0; BP[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0;
         for (int i = 0; i < 32; i++) mm[k][i] = '0;
      end

      // Reset two cycles, then clear with a write request at reg 5 during it
      rst = 1'b1; step(); step();
      rst = 1'b0;
      run_clear(1'b1, ca, cb);
      check("clear_len_a", ca, 32'd32);
      check("clear_len_b", cb, 32'd10);
      rs_addr = 5'd5; rt_addr = 5'd5; step();
      check("reg5_after_clear", rs_data[0], 32'h0);

      // Basic write/read via ALU then MDR
      write(5'd7, 1'b0, 32'h0000_00A5); rs_addr = 5'd0; rt_addr = 5'd0; step();
      regwrite = 1'b0; rs_addr = 5'd7; step();
      check("basic_alu_a", rs_data[0], 32'h0000_00A5);
      regwrite = 1'b1; regdst = 1'b0; rt_addr = 5'd3; memtoreg = 1'b1;
      mdr_result = 32'hDEAD_BEEF; rs_addr = 5'd0; step();
      regwrite = 1'b0; rs_addr = 5'd3; rt_addr = 5'd3; step();
      check("basic_mdr_a", rs_data[0], 32'hDEAD_BEEF);
      check("basic_mdr_b", rt_data[1], 32'hDEAD_BEEF);

      // Same-cycle write and dual read of reg 9
      write(5'd9, 1'b0, 32'h1234_5678); rs_addr = 5'd9; rt_addr = 5'd9; step();
      check("bypass_rs_a", rs_data[0], 32'h1234_5678);
      check("bypass_rt_a", rt_data[0], 32'h1234_5678);
      check("nobypass_rs_b", rs_data[1], 32'h0);
      regwrite = 1'b0; step();
      check("nobypass_next_b", rt_data[1], 32'h1234_5678);

      // Zero register
      write(5'd0, 1'b0, 32'hFFFF_FFFF); rs_addr = 5'd1; rt_addr = 5'd2; step();
      check("zero_drop_a", {31'b0, wr_drop[0]}, 32'h1);
      regwrite = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0; step();
      check("zero_read_a", rs_data[0], 32'h0);
      check("zero_read_b", rs_data[1], 32'hFFFF_FFFF);

      // Out-of-range write on the 10-entry instance
      write(5'd12, 1'b0, 32'hCAFE_0012); step();
      check("range_drop_b", {31'b0, wr_drop[1]}, 32'h1);
      regwrite = 1'b0; rs_addr = 5'd12; rt_addr = 5'd12; step();
      check("range_read_b", rs_data[1], 32'h0);
      for (int i = 0; i < 10; i++) begin
         rs_addr = 5'(i); rt_addr = 5'(9 - i); step();
      end

      // Reset at clear pointer 20 restarts the clear
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 20; i++) step();
      rst = 1'b1; step(); rst = 1'b0;
      run_clear(1'b0, ca, cb);
      check("restart_len_a", ca, 32'd32);
      check("restart_len_b", cb, 32'd10);

      // Reset after writing reg 4
      write(5'd4, 1'b0, 32'h0000_0055); step();
      regwrite = 1'b0; rs_addr = 5'd4; step();
      check("reg4_written", rs_data[0], 32'h0000_0055);
      rst = 1'b1; step(); rst = 1'b0;
      run_clear(1'b0, ca, cb);
      rs_addr = 5'd4; rt_addr = 5'd4; step();
      check("reg4_after_reset", rs_data[0], 32'h0);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 199) == 0);
         rs_addr    = 5'($urandom_range(0, 31));
         rt_addr    = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
         rd_addr    = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
         regdst     = 1'($urandom);
         regwrite   = ($urandom_range(0, 2) != 0);
         memtoreg   = 1'($urandom);
         alu_result = $urandom;
         mdr_result = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
